// File: rtl/video_stream_expander.sv
// ============================================================================
// video_stream_expander : packed RGB -> 30-bit VGA channel expander, show-ahead FIFO, SOP/EOP framing
// Revision: 1.0
// ============================================================================
`default_nettype none

module video_stream_expander #(
  parameter int IN_BITS      = 4,
  parameter int COLOUR_BITS  = 8,
  parameter int PAD_BITS     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [3*IN_BITS-1:0]                     pixel_in,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [1:0]                               mode,
  output logic [3*(COLOUR_BITS+PAD_BITS)-1:0]      data,
  output logic                                     valid,
  input  logic                                     ready,
  output logic                                     startofpacket,
  output logic                                     endofpacket
);

  localparam int CH_W  = COLOUR_BITS + PAD_BITS;
  localparam int OUT_W = 3 * CH_W;
  localparam int REP   = (COLOUR_BITS + IN_BITS - 1) / IN_BITS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(FIFO_DEPTH);
  localparam logic [PIX_W-1:0] C_LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

  function automatic logic [COLOUR_BITS-1:0] f_replicate(input logic [IN_BITS-1:0] c);
    logic [REP*IN_BITS-1:0] v_rep;
    v_rep = {REP{c}};
    return v_rep[REP*IN_BITS-1 -: COLOUR_BITS];
  endfunction

  function automatic logic [COLOUR_BITS-1:0] f_zext(input logic [IN_BITS-1:0] c);
    return COLOUR_BITS'(c) << (COLOUR_BITS - IN_BITS);
  endfunction

  function automatic logic [CH_W-1:0] f_pad(input logic [COLOUR_BITS-1:0] c);
    return CH_W'(c) << PAD_BITS;
  endfunction

  logic [IN_BITS-1:0]     w_r, w_g, w_b, w_y;
  logic [IN_BITS+1:0]     w_sum;
  logic [COLOUR_BITS-1:0] w_cr, w_cg, w_cb;
  logic [OUT_W-1:0]       w_wdata;
  logic                   w_empty, w_full, w_wr, w_rd;

  logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PIX_W-1:0] r_pix;

  always_comb begin
    w_r   = pixel_in[3*IN_BITS-1 -: IN_BITS];
    w_g   = pixel_in[2*IN_BITS-1 -: IN_BITS];
    w_b   = pixel_in[IN_BITS-1:0];
    // Two guard bits hold the full R + 2G + B sum without overflow.
    w_sum = {2'b00, w_r} + {1'b0, w_g, 1'b0} + {2'b00, w_b};
    w_y   = IN_BITS'(w_sum >> 2);
    w_cr  = f_replicate(w_r);
    w_cg  = f_replicate(w_g);
    w_cb  = f_replicate(w_b);
    case (mode)
      2'd1: begin
        w_cr = f_zext(w_r);
        w_cg = f_zext(w_g);
        w_cb = f_zext(w_b);
      end
      2'd2: begin
        w_cr = f_replicate(w_y);
        w_cg = f_replicate(w_y);
        w_cb = f_replicate(w_y);
      end
      2'd3: begin
        w_cr = ~f_replicate(w_r);
        w_cg = ~f_replicate(w_g);
        w_cb = ~f_replicate(w_b);
      end
      default: ;
    endcase
    w_wdata = {f_pad(w_cr), f_pad(w_cg), f_pad(w_cb)};
  end

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == C_FULL);
  assign in_ready = !reset && !w_full;
  assign valid    = !w_empty;
  assign w_wr     = in_valid && in_ready;
  assign w_rd     = valid && ready;

  assign data          = valid ? r_mem[r_rd_ptr] : '0;
  assign startofpacket = valid && (r_pix == '0);
  assign endofpacket   = valid && (r_pix == C_LAST_PIX);

  // Storage needs no reset: the empty count masks stale entries.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pix    <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_pix    <= (r_pix == C_LAST_PIX) ? '0 : r_pix + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
